muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle integer multiply/divide unit with its sequencing controller and architectural HI/LO registers for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX and iterates one bit per cycle.
- Raises a stall request, OR-ed into the pipeline flush/stall logic, while a younger MFHI/MFLO or another mul/div needs the result.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  EX-stage mul/div issue, sampled only in IDLE.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  in  WIDTH  rs value (multiplicand/dividend).
- OperandB  in  WIDTH  rt value (multiplier/divisor).
- HiLoRead  in  1  ID stage holds MFHI/MFLO.
- HiWrite  in  1  MTHI in EX.
- LoWrite  in  1  MTLO in EX.
- WriteData  in  WIDTH  MTHI/MTLO data.
- Busy  out  1  operation in flight.
- Stall  out  1  freeze PC and IF/ID, bubble ID/EX.
- Done  out  1  one-cycle pulse, HI/LO just updated.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (Rst=0, async): state IDLE, counter 0, Hi=Lo=0, Busy=Stall=Done=0, working registers 0. Asserting Rst mid-operation aborts it; no partial HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE → RUN on Start (cycle 0 edge). Captures |A| and |B| (signed ops) or the raw values (unsigned), result signs, and Op. Counter set to 0.
- IDLE → FIX directly when the op is DIV/DIVU with OperandB==0.
- RUN: one iteration per cycle, counter 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract.
  - Counter==WIDTH-1 → FIX.
- FIX: one cycle. Applies two's-complement sign correction.
  - Product negated if signA^signB.
  - Quotient negated if signA^signB.
  - Remainder takes the sign of the dividend.
  - Writes Hi/Lo at the end of the FIX cycle, then → IDLE.
- Results: MULT/MULTU Hi=product[2W-1:W], Lo=product[W-1:0]. DIV/DIVU Lo=quotient, Hi=remainder.
- Latency, start sampled in cycle 0:
  - RUN occupies cycles 1..32 and FIX is cycle 33.
  - Done=1 and new Hi/Lo are visible in cycle 34, where Busy=0.
  - Divide-by-zero: FIX in cycle 1, Done in cycle 2.
- Busy=1 in RUN and FIX; Busy=0 in IDLE.
- Stall = Busy & (HiLoRead | Start), combinational. Start while Busy is ignored; the stall holds that instruction in EX until IDLE.
- Done is registered, high exactly one cycle per completed operation, never asserted for MTHI/MTLO.
- Divide by zero (either signedness): Lo=all ones, Hi=OperandA unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, from wrap of the magnitude algorithm. No trap.
- MTHI/MTLO: HiWrite/LoWrite update Hi/Lo at the clock edge, only in IDLE; ignored while Busy.
- Simultaneous Start and HiWrite/LoWrite in IDLE: the write lands, the operation starts, and the operation's FIX result overwrites both registers.
- Operand ports are not sampled after cycle 0; later changes have no effect.
- Hi/Lo hold their value in all other cycles.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0x00000002 → cycle 34: Done=1, Hi=0x00000001, Lo=0xFFFFFFFE. Busy high in cycles 1–33.
- MULT A=0xFFFFFFFD (-3), B=0x00000007 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=0x00000002 → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU 100/7 → Lo=14, Hi=2.
- DIVU A=0x1234, B=0 → Done in cycle 2, Lo=0xFFFFFFFF, Hi=0x1234. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Hazards:
  - HiLoRead=1 in cycle 5 of a MULT → Stall=1 through cycle 33, Stall=0 in cycle 34.
  - A second Start in cycle 10 → Stall=1 and is ignored. Re-presented in cycle 34 it is accepted, and its Done arrives in cycle 68.
  - HiWrite during Busy → no effect. LoWrite 0xABCD in IDLE → Lo=0xABCD next cycle, Done stays 0.
- Rst pulsed low in cycle 20 of a DIV → Busy, Stall, Done, Hi and Lo all 0 immediately. No Done afterwards. A new Start after release completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: one bit per cycle
// (shift-add multiply, restoring divide), then a single sign-fix cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             hilo_read_i,
  input  logic             hi_write_i,
  input  logic             lo_write_i,
  input  logic [WIDTH-1:0] write_data_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q, dz_q, neg_res_q, neg_rem_q, done_q;
  logic [WIDTH-1:0]   opd_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               is_div, sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH:0]   div_sh;
  logic [2*WIDTH-1:0] step_d, neg_prod;
  logic [WIDTH-1:0]   fix_hi_d, fix_lo_d, rem, quo;

  assign is_div = op_i[1];
  assign sign_a = ~op_i[0] & operand_a_i[WIDTH-1];
  assign sign_b = ~op_i[0] & operand_b_i[WIDTH-1];
  assign abs_a  = sign_a ? -operand_a_i : operand_a_i;
  assign abs_b  = sign_b ? -operand_b_i : operand_b_i;

  // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opd_q} : '0);
    div_sh    = {prod_q, 1'b0};
    div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opd_q};
    step_d    = {mul_sum, prod_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) step_d = {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
      else                   step_d = div_sh[2*WIDTH-1:0];
    end
  end

  always_comb begin
    neg_prod = -prod_q;
    rem      = prod_q[2*WIDTH-1:WIDTH];
    quo      = prod_q[WIDTH-1:0];
    fix_hi_d = prod_q[2*WIDTH-1:WIDTH];
    fix_lo_d = prod_q[WIDTH-1:0];
    if (!dz_q) begin
      if (is_div_q) begin
        fix_hi_d = neg_rem_q ? -rem : rem;
        fix_lo_d = neg_res_q ? -quo : quo;
      end else if (neg_res_q) begin
        fix_hi_d = neg_prod[2*WIDTH-1:WIDTH];
        fix_lo_d = neg_prod[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      opd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_write_i) hi_q <= write_data_i;
          if (lo_write_i) lo_q <= write_data_i;
          if (start_i) begin
            is_div_q  <= is_div;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            cnt_q     <= '0;
            if (is_div && (operand_b_i == '0)) begin
              // Divide by zero: HI keeps the dividend, LO all ones.
              dz_q    <= 1'b1;
              prod_q  <= {operand_a_i, {WIDTH{1'b1}}};
              state_q <= FIX;
            end else begin
              dz_q    <= 1'b0;
              opd_q   <= is_div ? abs_b : abs_a;
              prod_q  <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          prod_q <= step_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o & (hilo_read_i | start_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, hazards, MTHI/MTLO, reset abort.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk_i, rst_ni, start_i, hilo_read_i, hi_write_i, lo_write_i;
  logic [1:0]  op_i, state_o;
  logic [31:0] operand_a_i, operand_b_i, write_data_i, hi_o, lo_o;
  logic        busy_o, stall_o, done_o;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .hilo_read_i(hilo_read_i),
    .hi_write_i(hi_write_i), .lo_write_i(lo_write_i), .write_data_i(write_data_i),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
    .state_o(state_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a start in the current cycle (cycle 0) and returns in cycle 1
  // with the operand ports scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i     = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    step();
    start_i     = 1'b0;
    operand_a_i = 32'hDEADBEEF;
    operand_b_i = 32'h0BADF00D;
  endtask

  // Counts cycles until done_o; lat = -1 if the bound expires.
  task automatic wait_done(input int cur, output int lat);
    lat = cur;
    while (!done_o && lat < 200) begin
      step();
      lat++;
    end
    if (!done_o) lat = -1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 0; op_i = 0; operand_a_i = 0; operand_b_i = 0;
    hilo_read_i = 1; hi_write_i = 0; lo_write_i = 0; write_data_i = 0;
    step(); step();
    checks++;
    if ({busy_o, stall_o, done_o} !== 3'b000 || hi_o !== 32'h0 || lo_o !== 32'h0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b stall=%b done=%b hi=%h lo=%h state=%0d, want all zero",
               busy_o, stall_o, done_o, hi_o, lo_o, state_o);
    end
    hilo_read_i = 0;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_multu();
    int bad;
    bad = 0;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
    for (int c = 1; c <= 33; c++) begin
      if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL multu_busy: %0d cycles in 1..33 with busy!=1 or done!=0, want 0", bad);
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || hi_o !== 32'h00000001 || lo_o !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_result: done=%b busy=%b hi=%h lo=%h, want done=1 busy=0 hi=00000001 lo=fffffffe",
               done_o, busy_o, hi_o, lo_o);
    end
    step();
    checks++;
    if (done_o !== 1'b0 || hi_o !== 32'h00000001 || lo_o !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_hold: done=%b hi=%h lo=%h, want done=0 hi=00000001 lo=fffffffe", done_o, hi_o, lo_o);
    end
  endtask

  task automatic test_mult();
    int lat;
    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
    wait_done(1, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_neg: lat=%0d hi=%h lo=%h, want lat=34 hi=ffffffff lo=ffffffeb", lat, hi_o, lo_o);
    end
    step();
  endtask

  task automatic test_div();
    int lat;
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(1, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_signed: lat=%0d hi=%h lo=%h, want lat=34 hi=ffffffff lo=fffffffd", lat, hi_o, lo_o);
    end
    step();
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++;
      $display("FAIL divu_100_7: lat=%0d hi=%0d lo=%0d, want lat=34 hi=2 lo=14", lat, hi_o, lo_o);
    end
    step();
  endtask

  task automatic test_div_zero();
    int lat;
    issue(OP_DIVU, 32'h00001234, 32'h0);
    wait_done(1, lat);
    checks++;
    if (lat != 2 || hi_o !== 32'h00001234 || lo_o !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL divu_zero: lat=%0d hi=%h lo=%h, want lat=2 hi=00001234 lo=ffffffff", lat, hi_o, lo_o);
    end
    step();
    issue(OP_DIV, 32'hFFFFFFF9, 32'h0);
    wait_done(1, lat);
    checks++;
    if (lat != 2 || hi_o !== 32'hFFFFFFF9 || lo_o !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_zero: lat=%0d hi=%h lo=%h, want lat=2 hi=fffffff9 lo=ffffffff", lat, hi_o, lo_o);
    end
    step();
  endtask

  task automatic test_overflow();
    int lat;
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'h0 || lo_o !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow: lat=%0d hi=%h lo=%h, want lat=34 hi=00000000 lo=80000000", lat, hi_o, lo_o);
    end
    step();
  endtask

  task automatic test_stall_read();
    int bad;
    bad = 0;
    issue(OP_MULT, 32'd5, 32'd6);
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) hilo_read_i = 1'b1;
      #1;
      if (stall_o !== (c >= 5)) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_read: %0d cycles in 1..33 with wrong stall, want 0", bad);
    end
    checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b1 || lo_o !== 32'd30 || hi_o !== 32'd0) begin
      errors++;
      $display("FAIL stall_release: stall=%b done=%b hi=%h lo=%h, want stall=0 done=1 hi=0 lo=30",
               stall_o, done_o, hi_o, lo_o);
    end
    hilo_read_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int bad, lat;
    bad = 0;
    issue(OP_MULTU, 32'd3, 32'd4);
    for (int c = 1; c <= 33; c++) begin
      if (c == 10) begin
        start_i = 1'b1; op_i = OP_DIVU; operand_a_i = 32'd100; operand_b_i = 32'd7;
      end
      #1;
      if (stall_o !== (c >= 10) || busy_o !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_stall: %0d cycles in 1..33 with wrong stall/busy, want 0", bad);
    end
    checks++;
    if (done_o !== 1'b1 || stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd12) begin
      errors++;
      $display("FAIL b2b_first: done=%b stall=%b hi=%h lo=%h, want done=1 stall=0 hi=0 lo=12",
               done_o, stall_o, hi_o, lo_o);
    end
    step();
    start_i = 1'b0; operand_a_i = 32'h11111111; operand_b_i = 32'h0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b in cycle 35, want 1", busy_o);
    end
    wait_done(35, lat);
    checks++;
    if (lat != 68 || hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++;
      $display("FAIL b2b_second: done cycle=%0d hi=%0d lo=%0d, want 68 hi=2 lo=14", lat, hi_o, lo_o);
    end
    step();
  endtask

  task automatic test_mthi_mtlo();
    int lat, bad;
    hi_write_i = 1'b1; write_data_i = 32'h00005555;
    step();
    hi_write_i = 1'b0;
    checks++;
    if (hi_o !== 32'h00005555 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL mthi_idle: hi=%h done=%b, want hi=00005555 done=0", hi_o, done_o);
    end
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (4) step();
    hi_write_i = 1'b1; write_data_i = 32'h0000DEAD;
    step();
    hi_write_i = 1'b0;
    checks++;
    if (hi_o !== 32'h00005555) begin
      errors++;
      $display("FAIL mthi_busy: hi=%h, want 00005555", hi_o);
    end
    wait_done(6, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'd0 || lo_o !== 32'd12) begin
      errors++;
      $display("FAIL mthi_busy_result: lat=%0d hi=%h lo=%h, want lat=34 hi=0 lo=12", lat, hi_o, lo_o);
    end
    step();
    lo_write_i = 1'b1; write_data_i = 32'h0000ABCD;
    step();
    lo_write_i = 1'b0;
    checks++;
    if (lo_o !== 32'h0000ABCD || hi_o !== 32'd0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_idle: lo=%h hi=%h done=%b, want lo=0000abcd hi=0 done=0", lo_o, hi_o, done_o);
    end
    bad = 0;
    repeat (3) begin
      step();
      if (done_o !== 1'b0 || lo_o !== 32'h0000ABCD) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mtlo_hold: %0d cycles with done or lo wrong, want 0", bad);
    end
    lo_write_i = 1'b1; write_data_i = 32'h00000077;
    issue(OP_MULTU, 32'd2, 32'd3);
    lo_write_i = 1'b0;
    checks++;
    if (lo_o !== 32'h00000077 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL start_and_mtlo: lo=%h busy=%b, want lo=00000077 busy=1", lo_o, busy_o);
    end
    wait_done(1, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'd0 || lo_o !== 32'd6) begin
      errors++;
      $display("FAIL start_and_mtlo_result: lat=%0d hi=%h lo=%h, want lat=34 hi=0 lo=6", lat, hi_o, lo_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, bad;
    bad = 0;
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (19) step();
    hilo_read_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, stall_o, done_o} !== 3'b000 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b stall=%b done=%b hi=%h lo=%h, want all zero",
               busy_o, stall_o, done_o, hi_o, lo_o);
    end
    step();
    rst_ni = 1'b1;
    hilo_read_i = 1'b0;
    repeat (40) begin
      step();
      if (done_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d cycles with done or busy set after abort, want 0", bad);
    end
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, lat);
    checks++;
    if (lat != 34 || hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++;
      $display("FAIL reset_restart: lat=%0d hi=%0d lo=%0d, want lat=34 hi=2 lo=14", lat, hi_o, lo_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_overflow();
    test_stall_read();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
